ifetch_unit: RTL
================

# ifetch_unit

Instruction-fetch sequencer for the single-cycle MIPS core. It owns the program counter, drives the address port of the combinational instruction memory (`Imem`), and buffers fetched words in a 2-entry queue. The queue feeds decode through a valid/ready handshake. Branch/jump redirects flush the queue, and a small run/halt/fault state machine gates fetching.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `IMEM_WORDS`, 64: number of implemented instruction words. Byte addresses at or above `IMEM_WORDS*4` are out of range.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: leave IDLE/HALTED and begin fetching.
- `halt`, in, 1: stop issuing new fetches.
- `redirect_valid`, in, 1: branch/jump taken this cycle.
- `redirect_pc`, in, 32: target byte address. Bits [1:0] are ignored and treated as 00.
- `imem_addr`, out, 32: address to `Imem`. Combinationally equal to `pc`.
- `imem_data`, in, 32: `Imem` read data, valid in the same cycle.
- `inst_valid`, out, 1: queue head is valid.
- `inst_ready`, in, 1: decode accepts the head.
- `inst_out`, out, 32: head instruction word.
- `inst_pc`, out, 32: byte address of the head instruction.
- `running`, out, 1: state == RUN.
- `fault`, out, 1: state == FAULT.

## Operation

States and transitions:
- **IDLE**
  - Reset state. No fetch.
  - `start` → RUN.
- **RUN**
  - Fetch one word per cycle when a push is allowed.
  - `halt` → HALTED.
  - Out-of-range `pc` → FAULT.
- **HALTED**
  - No fetch. The queue keeps draining to decode.
  - `start` → RUN.
- **FAULT**
  - No fetch.
  - `redirect_valid` → RUN, with the new PC.
  - Otherwise exits only on `reset`.

Priority, highest first:
- `reset`
- `redirect_valid`
- `halt`
- `start`

So `start` and `halt` asserted together in IDLE or HALTED leave the state unchanged.

Push rule:
- Push when state == RUN, `redirect_valid` == 0, `halt` == 0, `pc < IMEM_WORDS*4`, and (`count` < 2 or a pop happens this cycle).
- A push stores {`imem_data`, `pc`} at the tail and updates `pc <= pc + 4`.
- The PC increment is modulo 2^32; wrap to 0 is legal and is not itself a fault.

Pop rule:
- Pop occurs when `inst_valid && inst_ready`.
- Push and pop in the same cycle at `count` == 2 is allowed, and `count` stays 2.

Fault detection:
- Applies in RUN with `redirect_valid` == 0 and `halt` == 0, when `pc >= IMEM_WORDS*4`.
- No push occurs; state becomes FAULT and `pc` holds.
- Queued entries remain poppable.

Redirect, in any non-reset state:
- Queue is flushed (`count` <= 0).
- `pc <= {redirect_pc[31:2], 2'b00}`.
- No push or pop counts that cycle; any `inst_ready` is ignored.
- IDLE and HALTED keep their state; RUN stays RUN; FAULT → RUN.

Queue:
- 2 entries, `count` in 0..2.
- `inst_valid = (count != 0)`.
- `inst_out` and `inst_pc` come from registered storage; they are X-free (zero) when empty.

## Timing

Reset values (one cycle with `reset` high):
- `pc` = `RESET_PC`; `imem_addr` = `RESET_PC`.
- State IDLE; `count` = 0.
- `inst_valid` = 0, `inst_out` = 0, `inst_pc` = 0.
- `running` = 0, `fault` = 0.

Reset mid-operation discards queue contents and any pending redirect.

Latencies:
- `start` sampled in cycle N → `running` = 1 in N+1.
- First push at the end of N+1 → `inst_valid` = 1 in N+2.
- Fetch-to-`inst_valid` is 1 cycle.
- Redirect in cycle N:
  - `inst_valid` = 0 in N+1.
  - `imem_addr` = target in N+1.
  - First target instruction at `inst_valid` in N+2.
- `halt` in cycle N: no push in N; `running` = 0 in N+1.

Sustained rate:
- With `inst_ready` held high, one instruction per cycle.
- With `inst_ready` low, at most 2 words are fetched, then `pc` freezes until a pop.

Handshake:
- `inst_out` and `inst_pc` are stable while `inst_valid && !inst_ready`.
- `inst_valid` never drops without a pop, except on a redirect or reset.

## Test plan

- **Reset/start:**
  - Stimulus: `reset` for 2 cycles, then `start` for 1 cycle, `inst_ready` = 1, `Imem` preloaded with words at 0..36.
  - Required: `inst_pc` sequence 0, 4, 8, …, 36 on consecutive cycles starting 2 cycles after `start`, with `inst_out` matching memory.
- **Backpressure:**
  - Stimulus: `inst_ready` = 0 from cycle 3.
  - Required: `count` reaches 2, `imem_addr` freezes at 8, and the head holds pc 0.
  - Stimulus: raise `inst_ready`.
  - Required: 0, 4, 8 delivered in order, with no duplicate and no skip.
- **Redirect:**
  - Stimulus: while streaming, assert `redirect_valid` with `redirect_pc` = 0x1A at pc 12.
  - Required: queue flushed, `inst_valid` = 0 next cycle, then `inst_pc` = 0x18, 0x1C, ….
  - Stimulus: redirect coincident with `inst_ready` = 1.
  - Required: flush with no pop counted.
- **Halt/resume:**
  - Stimulus: `halt` at pc 16 with `inst_ready` = 1.
  - Required: already-queued words drain, `running` = 0, `imem_addr` holds 16.
  - Stimulus: `start` and `halt` together.
  - Required: stays HALTED.
  - Stimulus: `start` alone.
  - Required: resumes with `inst_pc` = 16.
- **Fault:**
  - Stimulus: `IMEM_WORDS` = 10, stream from 0.
  - Required: `fault` = 1 once pc = 40; last delivered `inst_pc` = 36.
  - Stimulus: redirect to 0.
  - Required: `fault` = 0, `running` = 1, fetch resumes at 0.
- **Reset mid-run and wrap:**
  - Stimulus: `reset` with `count` = 2.
  - Required: `inst_valid` = 0 next cycle, `pc` = `RESET_PC`.
  - Stimulus: `IMEM_WORDS` = 2^30, redirect to 0xFFFF_FFFC.
  - Required: next fetch address 0x0000_0000, no fault.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational Imem and
// buffers fetched words in a 2-entry queue with a valid/ready handshake to decode.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        running,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_e;

  // 34 bits so that IMEM_WORDS = 2^30 (the full 4 GiB space) compares correctly
  localparam logic [33:0] IMEM_BYTES = {IMEM_WORDS, 2'b00};

  state_e      state_q, state_d;
  logic        running_q, fault_q;
  logic [31:0] pc_q;
  logic [1:0]  count_q;
  logic [31:0] word_q [2];
  logic [31:0] wpc_q  [2];

  logic in_range, fetch_ok, pop, push, wr_sel;
  logic unused_rpc_lo;

  assign unused_rpc_lo = ^redirect_pc[1:0];

  assign in_range = ({2'b00, pc_q} < IMEM_BYTES);
  assign fetch_ok = (state_q == RUN) && !redirect_valid && !halt;
  assign pop      = inst_valid && inst_ready && !redirect_valid;
  assign push     = fetch_ok && in_range && ((count_q != 2'd2) || pop);
  // Tail slot after any same-cycle pop has shifted the head out
  assign wr_sel   = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      if (state_q == FAULT) state_d = RUN;
    end else if (halt) begin
      if (state_q == RUN) state_d = HALTED;
    end else if (state_q == RUN) begin
      if (!in_range) state_d = FAULT;
    end else if (start && (state_q == IDLE || state_q == HALTED)) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      fault_q   <= (state_d == FAULT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
    end else if (redirect_valid) begin
      pc_q    <= {redirect_pc[31:2], 2'b00};
      count_q <= 2'd0;
    end else begin
      if (push) pc_q <= pc_q + 32'd4;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue payload carries no reset; validity is tracked solely by count_q
  always_ff @(posedge clk) begin
    if (pop) begin
      word_q[0] <= word_q[1];
      wpc_q[0]  <= wpc_q[1];
    end
    if (push) begin
      word_q[wr_sel] <= imem_data;
      wpc_q[wr_sel]  <= pc_q;
    end
  end

  assign imem_addr  = pc_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst_out   = inst_valid ? word_q[0] : 32'd0;
  assign inst_pc    = inst_valid ? wpc_q[0]  : 32'd0;
  assign running    = running_q;
  assign fault      = fault_q;

endmodule
